// File: rtl/video_timing_pkg.sv
// Shared raster geometry and position types for the timing generator and text buffer.
package video_timing_pkg;

    localparam int unsigned CLK_DIV_DEF = 4;

    localparam int unsigned H_DISPLAY_DEF = 160;
    localparam int unsigned H_FRONT_DEF   = 8;
    localparam int unsigned H_SYNC_DEF    = 16;
    localparam int unsigned H_BACK_DEF    = 16;
    localparam int unsigned H_TOTAL       = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int unsigned V_DISPLAY_DEF = 120;
    localparam int unsigned V_FRONT_DEF   = 1;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 5;
    localparam int unsigned V_TOTAL       = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int unsigned HPOS_W  = 8;
    localparam int unsigned VPOS_W  = 7;
    localparam int unsigned FCOUNT_W = 8;

    typedef logic [HPOS_W-1:0]   hpos_t;
    typedef logic [VPOS_W-1:0]   vpos_t;
    typedef logic [FCOUNT_W-1:0] fcount_t;

endpackage

// File: rtl/video_timing_pixel_ce_div.sv
// Clock divider: one registered pix_ce strobe every CLK_DIV system clocks.
module video_timing_pixel_ce_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pix_ce
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_ce_q, pix_ce_d;

    // Next divider phase; strobe is aligned with the phase it is computed from.
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        pix_ce_d = (div_d == DIV_LAST);
    end

    // Divider state, cleared synchronously.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            pix_ce_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_ce_q <= pix_ce_d;
        end
    end

    assign pix_ce = pix_ce_q;

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: pixel/line counters with registered sync, blank and frame events.
module video_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                irq_ack,
    output logic                pix_ce,
    output logic [HPOS_W-1:0]   hpos,
    output logic [VPOS_W-1:0]   vpos,
    output logic                hsync,
    output logic                vsync,
    output logic                display_on,
    output logic                line_start,
    output logic                frame_start,
    output logic                vblank_irq,
    output logic [FCOUNT_W-1:0] frame_count
);

    localparam int unsigned H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam hpos_t H_LAST   = HPOS_W'(H_TOT - 1);
    localparam hpos_t H_VIS    = HPOS_W'(H_DISPLAY);
    localparam hpos_t HS_FIRST = HPOS_W'(H_DISPLAY + H_FRONT);
    localparam hpos_t HS_LAST  = HPOS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam vpos_t V_LAST   = VPOS_W'(V_TOT - 1);
    localparam vpos_t V_VIS    = VPOS_W'(V_DISPLAY);
    localparam vpos_t V_PREBLK = VPOS_W'(V_DISPLAY - 1);
    localparam vpos_t VS_FIRST = VPOS_W'(V_DISPLAY + V_FRONT);
    localparam vpos_t VS_LAST  = VPOS_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic    pix_ce_w;
    hpos_t   hpos_q, hpos_d;
    vpos_t   vpos_q, vpos_d;
    logic    hsync_q, hsync_d;
    logic    vsync_q, vsync_d;
    logic    display_on_q, display_on_d;
    logic    line_start_q, line_start_d;
    logic    frame_start_q, frame_start_d;
    logic    irq_q, irq_d;
    fcount_t frame_count_q, frame_count_d;

    video_timing_pixel_ce_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .pix_ce (pix_ce_w)
    );

    // Position advance, wrap events and vblank interrupt (entry beats ack).
    always_comb begin
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;
        irq_d         = irq_q;
        if (irq_ack) begin
            irq_d = 1'b0;
        end
        if (pix_ce_w) begin
            if (hpos_q == H_LAST) begin
                hpos_d       = '0;
                line_start_d = 1'b1;
                if (vpos_q == V_LAST) begin
                    vpos_d        = '0;
                    frame_start_d = 1'b1;
                    frame_count_d = frame_count_q + FCOUNT_W'(1);
                end else begin
                    vpos_d = vpos_q + VPOS_W'(1);
                end
                if (vpos_q == V_PREBLK) begin
                    irq_d = 1'b1;
                end
            end else begin
                hpos_d = hpos_q + HPOS_W'(1);
            end
        end
    end

    // Decode from the next position so sync/blank land on the same edge as hpos/vpos.
    always_comb begin
        hsync_d      = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST)) ? HS_POL : ~HS_POL;
        vsync_d      = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST)) ? VS_POL : ~VS_POL;
        display_on_d = (hpos_d < H_VIS) && (vpos_d < V_VIS);
    end

    // Timing state registers, cleared synchronously to the top-left of the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q        <= '0;
            vpos_q        <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            display_on_q  <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            irq_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            irq_q         <= irq_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pix_ce      = pix_ce_w;
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign vblank_irq  = irq_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: default geometry instance plus a small fast-frame instance.
module tb_video_timing;

    typedef struct {
        int unsigned d;
        int unsigned hd, hf, hs, hb;
        int unsigned vd, vf, vs, vb;
        bit          hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic       pix_ce;
        logic [7:0] hpos;
        logic [6:0] vpos;
        logic       hsync;
        logic       vsync;
        logic       display_on;
        logic       line_start;
        logic       frame_start;
        logic       vblank_irq;
        logic [7:0] frame_count;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, ack_a, rst_b, ack_b;
    logic pix_ce_a, hsync_a, vsync_a, display_on_a, line_start_a, frame_start_a, vblank_irq_a;
    logic pix_ce_b, hsync_b, vsync_b, display_on_b, line_start_b, frame_start_b, vblank_irq_b;
    logic [7:0] hpos_a, hpos_b, frame_count_a, frame_count_b;
    logic [6:0] vpos_a, vpos_b;

    video_timing dut_a (
        .clk(clk), .reset(rst_a), .irq_ack(ack_a), .pix_ce(pix_ce_a),
        .hpos(hpos_a), .vpos(vpos_a), .hsync(hsync_a), .vsync(vsync_a),
        .display_on(display_on_a), .line_start(line_start_a),
        .frame_start(frame_start_a), .vblank_irq(vblank_irq_a),
        .frame_count(frame_count_a)
    );

    video_timing #(
        .CLK_DIV(2), .H_DISPLAY(6), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .clk(clk), .reset(rst_b), .irq_ack(ack_b), .pix_ce(pix_ce_b),
        .hpos(hpos_b), .vpos(vpos_b), .hsync(hsync_b), .vsync(vsync_b),
        .display_on(display_on_b), .line_start(line_start_b),
        .frame_start(frame_start_b), .vblank_irq(vblank_irq_b),
        .frame_count(frame_count_b)
    );

    obs_t act_a, act_b;
    assign act_a = {pix_ce_a, hpos_a, vpos_a, hsync_a, vsync_a, display_on_a,
                    line_start_a, frame_start_a, vblank_irq_a, frame_count_a};
    assign act_b = {pix_ce_b, hpos_b, vpos_b, hsync_b, vsync_b, display_on_b,
                    line_start_b, frame_start_b, vblank_irq_b, frame_count_b};

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          chk_en   = 1'b0;
    cfg_t        cfg_a, cfg_b;

    // Expected outputs k clocks after reset release, from elapsed-time arithmetic.
    function automatic obs_t model_obs(input cfg_t c, input int unsigned k, input bit irq);
        obs_t o;
        int unsigned ht, vt, n, line, h, v;
        ht   = c.hd + c.hf + c.hs + c.hb;
        vt   = c.vd + c.vf + c.vs + c.vb;
        n    = k / c.d;
        h    = n % ht;
        line = n / ht;
        v    = line % vt;
        o.pix_ce      = ((k % c.d) == c.d - 1);
        o.hpos        = 8'(h);
        o.vpos        = 7'(v);
        o.hsync       = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? c.hpol : ~c.hpol;
        o.vsync       = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? c.vpol : ~c.vpol;
        o.display_on  = (h < c.hd) && (v < c.vd);
        o.line_start  = (k != 0) && ((k % c.d) == 0) && (h == 0);
        o.frame_start = o.line_start && (v == 0);
        o.vblank_irq  = irq;
        o.frame_count = 8'((line / vt) % 256);
        return o;
    endfunction

    function automatic bit vblank_entry(input cfg_t c, input int unsigned k);
        obs_t o;
        o = model_obs(c, k, 1'b0);
        return o.line_start && (32'(o.vpos) == c.vd);
    endfunction

    // Model time and sticky interrupt per instance.
    int unsigned k_a = 0, k_b = 0;
    bit          irq_a = 1'b0, irq_b = 1'b0;

    always @(posedge clk) begin
        if (rst_a) begin
            k_a <= 0; irq_a <= 1'b0;
        end else begin
            k_a   <= k_a + 1;
            irq_a <= vblank_entry(cfg_a, k_a + 1) ? 1'b1 : (ack_a ? 1'b0 : irq_a);
        end
        if (rst_b) begin
            k_b <= 0; irq_b <= 1'b0;
        end else begin
            k_b   <= k_b + 1;
            irq_b <= vblank_entry(cfg_b, k_b + 1) ? 1'b1 : (ack_b ? 1'b0 : irq_b);
        end
    end

    task automatic cmp_obs(input string tag, input int unsigned k, input obs_t g, input obs_t e);
        n_checks++;
        if (g === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s k=%0d got{ce=%b h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b irq=%b fc=%0d} expected{ce=%b h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b irq=%b fc=%0d}",
                     tag, k, g.pix_ce, g.hpos, g.vpos, g.hsync, g.vsync, g.display_on,
                     g.line_start, g.frame_start, g.vblank_irq, g.frame_count,
                     e.pix_ce, e.hpos, e.vpos, e.hsync, e.vsync, e.display_on,
                     e.line_start, e.frame_start, e.vblank_irq, e.frame_count);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_obs("model_a", k_a, act_a, model_obs(cfg_a, k_a, irq_a));
            cmp_obs("model_b", k_b, act_b, model_obs(cfg_b, k_b, irq_b));
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int unsigned ka, kb, hs_low;
    logic [7:0]  hs_first, hs_last;
    bit          seen;

    initial begin
        cfg_a = '{d: 4, hd: 160, hf: 8, hs: 16, hb: 16, vd: 120, vf: 1, vs: 2, vb: 5, hpol: 1'b0, vpol: 1'b0};
        cfg_b = '{d: 2, hd: 6, hf: 2, hs: 2, hb: 2, vd: 3, vf: 1, vs: 1, vb: 1, hpol: 1'b1, vpol: 1'b1};
        rst_a = 1'b1; rst_b = 1'b1; ack_a = 1'b0; ack_b = 1'b0;
        hs_low = 0; seen = 1'b0; hs_first = '0; hs_last = '0;
        repeat (3) tick();
        chk_en = 1'b1;

        // Reset values on the default instance.
        lit("a_rst_hpos", 32'(hpos_a), 0);
        lit("a_rst_vpos", 32'(vpos_a), 0);
        lit("a_rst_hsync", 32'(hsync_a), 1);
        lit("a_rst_vsync", 32'(vsync_a), 1);
        lit("a_rst_de", 32'(display_on_a), 1);
        lit("a_rst_irq", 32'(vblank_irq_a), 0);
        lit("a_rst_fc", 32'(frame_count_a), 0);
        lit("a_rst_ce", 32'(pix_ce_a), 0);

        // Release: first strobe on the fourth clock, first advance on the fifth.
        rst_a = 1'b0; ka = 0;
        repeat (3) tick();
        ka = 3;
        lit("a_ce_first", 32'(pix_ce_a), 1);
        lit("a_h_before", 32'(hpos_a), 0);
        tick(); ka = 4;
        lit("a_h1", 32'(hpos_a), 1);
        lit("a_ce_off", 32'(pix_ce_a), 0);

        // Line 0: hsync low window and horizontal blanking edge.
        while (ka < 800) begin
            if (hsync_a == 1'b0 && vpos_a == 7'd0) begin
                hs_low++;
                if (!seen) begin hs_first = hpos_a; seen = 1'b1; end
                hs_last = hpos_a;
            end
            if (ka == 636) lit("a_de_h159", 32'(display_on_a), 1);
            if (ka == 640) lit("a_de_h160", 32'(display_on_a), 0);
            if (ka == 799) lit("a_h199", 32'(hpos_a), 199);
            tick(); ka++;
        end
        lit("a_hs_low_clks", hs_low, 64);
        lit("a_hs_first", 32'(hs_first), 168);
        lit("a_hs_last", 32'(hs_last), 183);
        lit("a_wrap_h", 32'(hpos_a), 0);
        lit("a_wrap_v", 32'(vpos_a), 1);
        lit("a_ls_on", 32'(line_start_a), 1);
        lit("a_fs_off", 32'(frame_start_a), 0);
        tick(); ka++;
        lit("a_ls_off", 32'(line_start_a), 0);

        // Reset in the middle of a line.
        while (ka < 1160) begin tick(); ka++; end
        lit("a_mid_h", 32'(hpos_a), 90);
        rst_a = 1'b1;
        tick();
        lit("a_mrst_h", 32'(hpos_a), 0);
        lit("a_mrst_v", 32'(vpos_a), 0);
        lit("a_mrst_hs", 32'(hsync_a), 1);
        lit("a_mrst_de", 32'(display_on_a), 1);
        lit("a_mrst_ce", 32'(pix_ce_a), 0);

        // Small instance: vblank interrupt set/ack, vsync, frame events.
        rst_b = 1'b0; kb = 0;
        tick(); kb = 1;
        lit("b_ce_first", 32'(pix_ce_b), 1);
        while (kb < 71) begin tick(); kb++; end
        lit("b_pre_v", 32'(vpos_b), 2);
        lit("b_pre_h", 32'(hpos_b), 11);
        lit("b_pre_irq", 32'(vblank_irq_b), 0);
        tick(); kb++;
        lit("b_vbl_v", 32'(vpos_b), 3);
        lit("b_vbl_irq", 32'(vblank_irq_b), 1);
        lit("b_vbl_de", 32'(display_on_b), 0);
        while (kb < 75) begin tick(); kb++; end
        lit("b_irq_held", 32'(vblank_irq_b), 1);
        ack_b = 1'b1;
        tick(); kb++;
        ack_b = 1'b0;
        lit("b_irq_acked", 32'(vblank_irq_b), 0);
        while (kb < 95) begin tick(); kb++; end
        lit("b_vs_before", 32'(vsync_b), 0);
        while (kb < 100) begin tick(); kb++; end
        lit("b_vs_active", 32'(vsync_b), 1);
        while (kb < 144) begin tick(); kb++; end
        lit("b_fs_on", 32'(frame_start_b), 1);
        lit("b_fc1", 32'(frame_count_b), 1);
        lit("b_f_h", 32'(hpos_b), 0);
        lit("b_f_v", 32'(vpos_b), 0);
        while (kb < 215) begin tick(); kb++; end
        ack_b = 1'b1;
        tick(); kb++;
        ack_b = 1'b0;
        lit("b_set_beats_ack", 32'(vblank_irq_b), 1);
        while (kb < 36863) begin tick(); kb++; end
        lit("b_fc255", 32'(frame_count_b), 255);
        tick(); kb++;
        lit("b_fc_wrap", 32'(frame_count_b), 0);
        lit("b_fs_wrap", 32'(frame_start_b), 1);
        repeat (4) tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
